// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and constants for the FIFO read-side burst consumer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fifo_burst_reader_pkg;

    localparam int RD_BUF_DEPTH = 3;
    localparam int DEF_DW       = 8;
    localparam int DEF_LENW     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } rd_state_e;

    // True while the skid buffer can still absorb every word already popped.
    function automatic logic credit_avail(input logic [1:0] occ, input logic inflight);
        return ({1'b0, occ} + {2'b00, inflight}) < 3'(RD_BUF_DEPTH);
    endfunction

endpackage

// File: rtl/fifo_burst_reader_if.sv
// Command, FIFO read port and output stream bundle for fifo_burst_reader.
// Latency: n/a (wires only).
// Backpressure: cmd_valid/cmd_ready and m_valid/m_ready handshakes carried as-is.
interface fifo_burst_reader_if
    import fifo_burst_reader_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int LENW = DEF_LENW
);
    logic            cmd_valid;
    logic [LENW-1:0] cmd_len;
    logic            cmd_ready;
    logic            fifo_empty;
    logic [DW-1:0]   fifo_data;
    logic            fifo_pop;
    logic [DW-1:0]   m_data;
    logic            m_valid;
    logic            m_ready;
    logic            done;
    logic            done_timeout;

    // Environment side: issues commands, models the FIFO, consumes the stream.
    modport master (
        output cmd_valid, cmd_len, fifo_empty, fifo_data, m_ready,
        input  cmd_ready, fifo_pop, m_data, m_valid, done, done_timeout
    );

    // Reader side.
    modport slave (
        input  cmd_valid, cmd_len, fifo_empty, fifo_data, m_ready,
        output cmd_ready, fifo_pop, m_data, m_valid, done, done_timeout
    );

endinterface

// File: rtl/fifo_burst_reader_skid.sv
// 3-entry in-order output buffer feeding the m_valid/m_ready stream.
// Latency: word written in cycle t is presented as head in t+1 at the earliest.
// Backpressure: holds words while m_ready is low; writer must never exceed 3 entries.
module fifo_rd_skid
    import fifo_burst_reader_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [1:0]    occ
);

    logic [DW-1:0] mem [RD_BUF_DEPTH];
    logic [1:0]    occ_q;
    logic          hs;
    logic [1:0]    wr_idx;

    assign hs      = m_valid && m_ready;
    assign m_valid = (occ_q != 2'd0);
    assign m_data  = mem[0];
    assign occ     = occ_q;
    // A departing head shifts everything down, so the new word lands one slot lower.
    assign wr_idx  = hs ? (occ_q - 2'd1) : occ_q;

    // Shift-on-pop storage; a same-cycle write overrides the shifted slot it targets.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
            occ_q <= '0;
        end else begin
            if (hs) begin
                for (int i = 0; i < RD_BUF_DEPTH - 1; i++) begin
                    mem[i] <= mem[i+1];
                end
            end
            if (wr_en && (wr_idx < 2'(RD_BUF_DEPTH))) begin
                mem[wr_idx] <= wr_data;
            end
            occ_q <= occ_q + 2'(wr_en) - 2'(hs);
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops a commanded burst from the FIFO read port and streams it out with a done pulse (timeout abort under FIFO_RD_TIMEOUT_EN).
// Latency: pop in t -> m_valid in t+2; done the cycle after the last output handshake.
// Backpressure: pops only while occ+inflight < 3, so m_ready stalls never lose data; cmd_ready only in IDLE.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int LENW    = DEF_LENW,
    parameter int TIMEOUT = 64
) (
    input logic                 rdclk,
    input logic                 rd_rst,
    fifo_burst_reader_if.slave  bus
);

    rd_state_e       state_q, state_d;
    logic [LENW-1:0] rem_pop_q, rem_pop_d;
    logic [LENW-1:0] rem_out_q, rem_out_d;
    logic            inflight_q;
    logic [1:0]      occ;
    logic            hs;
    logic            pop;
    logic            timeout_hit;

    assign hs = bus.m_valid && bus.m_ready;

    // Pop decision uses only registered occupancy, never m_ready.
    assign pop = (state_q == RUN) && !timeout_hit && !bus.fifo_empty &&
                 (rem_pop_q != '0) && credit_avail(occ, inflight_q);
    assign bus.fifo_pop = pop;

`ifdef FIFO_RD_TIMEOUT_EN
    localparam int STW = $clog2(TIMEOUT + 1);

    logic [STW-1:0] stall_q;
    logic           to_flag_q;

    assign timeout_hit      = (state_q == RUN) && (stall_q == STW'(TIMEOUT));
    assign bus.done_timeout = (state_q == DONE) && to_flag_q;

    // Count consecutive empty-FIFO cycles while words are still owed.
    always_ff @(posedge rdclk or posedge rd_rst) begin
        if (rd_rst) begin
            stall_q <= '0;
        end else if (pop || (state_q != RUN)) begin
            stall_q <= '0;
        end else if (bus.fifo_empty && (rem_pop_q != '0) && (stall_q != STW'(TIMEOUT))) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    // Remember that this burst was aborted so DONE can report it.
    always_ff @(posedge rdclk or posedge rd_rst) begin
        if (rd_rst) begin
            to_flag_q <= 1'b0;
        end else if (timeout_hit) begin
            to_flag_q <= 1'b1;
        end else if (state_q == IDLE) begin
            to_flag_q <= 1'b0;
        end
    end
`else
    // Constant false; TIMEOUT only matters when the stall counter is built.
    assign timeout_hit      = (TIMEOUT < 0);
    assign bus.done_timeout = 1'b0;
`endif

    // FSM next-state, counters and handshake outputs.
    always_comb begin
        state_d       = state_q;
        rem_pop_d     = rem_pop_q;
        rem_out_d     = rem_out_q - LENW'(hs);
        bus.cmd_ready = 1'b0;
        bus.done      = 1'b0;
        case (state_q)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    rem_pop_d = bus.cmd_len;
                    rem_out_d = bus.cmd_len;
                    state_d   = (bus.cmd_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (timeout_hit) begin
                    // Only words already buffered or in flight are still delivered.
                    rem_pop_d = '0;
                    rem_out_d = LENW'(occ) + LENW'(inflight_q) - LENW'(hs);
                    state_d   = FLUSH;
                end else if (pop) begin
                    rem_pop_d = rem_pop_q - 1'b1;
                    if (rem_pop_q == LENW'(1)) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // Look at the post-handshake count so done lands right after the last word.
                if (rem_out_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, burst counters and the one-cycle pop-to-data pipeline flag.
    always_ff @(posedge rdclk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q    <= IDLE;
            rem_pop_q  <= '0;
            rem_out_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_pop_q  <= rem_pop_d;
            rem_out_q  <= rem_out_d;
            inflight_q <= pop;
        end
    end

    fifo_rd_skid #(.DW(DW)) u_skid (
        .clk     (rdclk),
        .rst     (rd_rst),
        .wr_en   (inflight_q),
        .wr_data (bus.fifo_data),
        .m_valid (bus.m_valid),
        .m_ready (bus.m_ready),
        .m_data  (bus.m_data),
        .occ     (occ)
    );

endmodule
